// File: rtl/remote_req_arbiter.sv
// rtl/remote_req_arbiter.sv - two-requester remote request arbiter with tx/outstanding credits and fence drain
//
// Purpose:
//   Arbitrates between the icache-miss fetch path and the load/store unit for a
//   single network transmit port. A request is issued only when a downstream
//   transmit credit and an outstanding-request credit are both available. When
//   both requesters are valid, the one not granted most recently wins. A fence
//   stops issue and waits until every outstanding request has been answered.
//
// Ports:
//   clk_i, reset_n_i            clock, synchronous active-low reset
//   ifetch_v_i/ifetch_req_i     icache-miss request valid and payload
//   ifetch_ready_o              icache-miss request accepted this cycle
//   lsu_v_i/lsu_req_i           LSU request valid and payload
//   lsu_ready_o                 LSU request accepted this cycle
//   remote_req_v_o/remote_req_o registered request toward the network (valid-credit)
//   remote_req_credit_i         one transmit credit returned
//   resp_done_i                 one remote response retired
//   fence_i                     level request to drain all outstanding requests
//   fence_done_o                single-cycle pulse when the drain completes
//   out_credits_o               current outstanding-credit count

module remote_req_arbiter #(
    parameter int req_width_p       = 32,
    parameter int tx_credits_p      = 2,
    parameter int max_out_credits_p = 16,
    localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic                       ifetch_v_i,
    input  logic [req_width_p-1:0]     ifetch_req_i,
    output logic                       ifetch_ready_o,

    input  logic                       lsu_v_i,
    input  logic [req_width_p-1:0]     lsu_req_i,
    output logic                       lsu_ready_o,

    output logic                       remote_req_v_o,
    output logic [req_width_p-1:0]     remote_req_o,
    input  logic                       remote_req_credit_i,

    input  logic                       resp_done_i,

    input  logic                       fence_i,
    output logic                       fence_done_o,

    output logic [credit_width_lp-1:0] out_credits_o
);

    localparam int tx_width_lp = $clog2(tx_credits_p + 1);

    localparam logic [tx_width_lp-1:0]     tx_full_lp  = tx_width_lp'(tx_credits_p);
    localparam logic [credit_width_lp-1:0] out_full_lp = credit_width_lp'(max_out_credits_p);

    typedef enum logic {
        st_normal,
        st_drain
    } state_e;

    typedef enum logic {
        src_ifetch,
        src_lsu
    } src_e;

    state_e                     state;
    src_e                       last_grant;
    logic [tx_width_lp-1:0]     tx_cnt;
    logic [credit_width_lp-1:0] out_cnt;

    logic                       tx_avail;
    logic                       can_issue;
    logic                       pick_ifetch;
    logic                       grant;
    logic [tx_width_lp-1:0]     tx_cnt_next;
    logic [credit_width_lp-1:0] out_cnt_next;

    // A transmit credit arriving this cycle may be spent in the same cycle, so a
    // requester starved of tx credits is granted as soon as one comes back.
    assign tx_avail = (tx_cnt != '0) || remote_req_credit_i;

    assign can_issue = reset_n_i
                    && tx_avail
                    && (out_cnt != '0)
                    && (state == st_normal)
                    && !fence_i;

    // Round-robin tie break: ifetch wins unless it was the most recent winner.
    assign pick_ifetch = ifetch_v_i && (!lsu_v_i || (last_grant == src_lsu));

    assign ifetch_ready_o = can_issue && pick_ifetch;
    assign lsu_ready_o    = can_issue && lsu_v_i && !pick_ifetch;
    assign grant          = ifetch_ready_o || lsu_ready_o;

    // Simultaneous issue and return cancel out. A return at full count is a
    // protocol error; the counter saturates instead of wrapping.
    always_comb begin
        tx_cnt_next = tx_cnt;
        if (remote_req_credit_i && !grant) begin
            if (tx_cnt != tx_full_lp) begin
                tx_cnt_next = tx_cnt + 1'b1;
            end
        end else if (!remote_req_credit_i && grant) begin
            tx_cnt_next = tx_cnt - 1'b1;
        end
    end

    always_comb begin
        out_cnt_next = out_cnt;
        if (resp_done_i && !grant) begin
            if (out_cnt != out_full_lp) begin
                out_cnt_next = out_cnt + 1'b1;
            end
        end else if (!resp_done_i && grant) begin
            out_cnt_next = out_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state          <= st_normal;
            last_grant     <= src_lsu;
            tx_cnt         <= tx_full_lp;
            out_cnt        <= out_full_lp;
            remote_req_v_o <= 1'b0;
            remote_req_o   <= '0;
            fence_done_o   <= 1'b0;
        end else begin
            tx_cnt         <= tx_cnt_next;
            out_cnt        <= out_cnt_next;
            remote_req_v_o <= grant;
            fence_done_o   <= 1'b0;

            if (grant) begin
                remote_req_o <= ifetch_ready_o ? ifetch_req_i : lsu_req_i;
                last_grant   <= ifetch_ready_o ? src_ifetch : src_lsu;
            end

            case (state)
                st_normal: begin
                    if (fence_i) begin
                        state <= st_drain;
                    end
                end
                // The drain ignores fence_i once entered; it ends when every
                // outstanding credit is back, including one returning this cycle.
                st_drain: begin
                    if (out_cnt_next == out_full_lp) begin
                        state        <= st_normal;
                        fence_done_o <= 1'b1;
                    end
                end
                default: begin
                    state <= st_normal;
                end
            endcase
        end
    end

    assign out_credits_o = out_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            tx_credit_overflow: assert (!(remote_req_credit_i && (tx_cnt == tx_full_lp)));
            resp_done_overflow: assert (!(resp_done_i && (out_cnt == out_full_lp)));
        end
    end

endmodule

// File: tb/tb_remote_req_arbiter.sv
// tb/tb_remote_req_arbiter.sv - directed self-checking bench for remote_req_arbiter
module tb_remote_req_arbiter;

    localparam int w_lp   = 8;
    localparam int tx_lp  = 2;
    localparam int max_lp = 4;
    localparam int cw_lp  = $clog2(max_lp + 1);

    logic              clk = 1'b0;
    logic              reset_n;
    logic              ifetch_v;
    logic [w_lp-1:0]   ifetch_req;
    logic              ifetch_ready;
    logic              lsu_v;
    logic [w_lp-1:0]   lsu_req;
    logic              lsu_ready;
    logic              remote_req_v;
    logic [w_lp-1:0]   remote_req;
    logic              remote_req_credit;
    logic              resp_done;
    logic              fence;
    logic              fence_done;
    logic [cw_lp-1:0]  out_credits;

    int n_compared   = 0;
    int n_mismatched = 0;
    int grants;

    always #5 clk = ~clk;

    remote_req_arbiter #(
        .req_width_p       (w_lp),
        .tx_credits_p      (tx_lp),
        .max_out_credits_p (max_lp)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .ifetch_v_i          (ifetch_v),
        .ifetch_req_i        (ifetch_req),
        .ifetch_ready_o      (ifetch_ready),
        .lsu_v_i             (lsu_v),
        .lsu_req_i           (lsu_req),
        .lsu_ready_o         (lsu_ready),
        .remote_req_v_o      (remote_req_v),
        .remote_req_o        (remote_req),
        .remote_req_credit_i (remote_req_credit),
        .resp_done_i         (resp_done),
        .fence_i             (fence),
        .fence_done_o        (fence_done),
        .out_credits_o       (out_credits)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pulse(input int n_credit, input int n_resp);
        int n;
        n = (n_credit > n_resp) ? n_credit : n_resp;
        for (int i = 0; i < n; i++) begin
            remote_req_credit = (i < n_credit);
            resp_done         = (i < n_resp);
            next_cycle();
        end
        remote_req_credit = 1'b0;
        resp_done         = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n           = 1'b0;
        ifetch_v          = 1'b1;
        lsu_v             = 1'b1;
        ifetch_req        = 8'hA5;
        lsu_req           = 8'h3C;
        remote_req_credit = 1'b0;
        resp_done         = 1'b0;
        fence             = 1'b0;

        next_cycle();
        next_cycle();
        settle();
        check("rst_ifetch_ready", ifetch_ready, 0);
        check("rst_lsu_ready", lsu_ready, 0);
        check("rst_req_v", remote_req_v, 0);
        check("rst_req", remote_req, 0);
        check("rst_fence_done", fence_done, 0);
        check("rst_out_credits", out_credits, max_lp);

        // Tie after reset: ifetch first, then lsu, then tx credits exhausted.
        reset_n = 1'b1;
        settle();
        check("tie_c0_ifetch_ready", ifetch_ready, 1);
        check("tie_c0_lsu_ready", lsu_ready, 0);
        next_cycle();
        settle();
        check("tie_c1_req_v", remote_req_v, 1);
        check("tie_c1_req", remote_req, 8'hA5);
        check("tie_c1_ifetch_ready", ifetch_ready, 0);
        check("tie_c1_lsu_ready", lsu_ready, 1);
        next_cycle();
        settle();
        check("tie_c2_req_v", remote_req_v, 1);
        check("tie_c2_req", remote_req, 8'h3C);
        check("tie_c2_ifetch_ready", ifetch_ready, 0);
        check("tie_c2_lsu_ready", lsu_ready, 0);
        check("tie_c2_tx_cnt", dut.tx_cnt, 0);
        check("tie_c2_out_credits", out_credits, 2);
        ifetch_v = 1'b0;
        lsu_v    = 1'b0;
        next_cycle();
        settle();
        check("tie_c3_req_v", remote_req_v, 0);
        check("tie_c3_req_hold", remote_req, 8'h3C);
        pulse(2, 2);
        settle();
        check("restore_tx_cnt", dut.tx_cnt, tx_lp);
        check("restore_out_credits", out_credits, max_lp);

        // Credit starvation: lsu valid 5 cycles, then a credit in cycle 5.
        lsu_v  = 1'b1;
        grants = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            grants += int'(lsu_ready);
            next_cycle();
        end
        check("starve_grants", grants, 2);
        remote_req_credit = 1'b1;
        settle();
        check("starve_credit_grant", lsu_ready, 1);
        next_cycle();
        remote_req_credit = 1'b0;
        lsu_v             = 1'b0;
        settle();
        check("starve_tx_cnt", dut.tx_cnt, 0);
        check("starve_out_credits", out_credits, 1);
        pulse(2, 3);

        // Outstanding limit: credits returned right after each grant, no responses.
        lsu_v  = 1'b1;
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            remote_req_credit = (i >= 1 && i <= 4);
            settle();
            grants += int'(lsu_ready);
            next_cycle();
        end
        remote_req_credit = 1'b0;
        settle();
        check("outlim_grants", grants, 4);
        check("outlim_out_credits", out_credits, 0);
        grants = 0;
        for (int i = 0; i < 4; i++) begin
            resp_done         = (i == 0);
            remote_req_credit = (i == 2);
            settle();
            grants += int'(lsu_ready);
            next_cycle();
        end
        lsu_v             = 1'b0;
        resp_done         = 1'b0;
        remote_req_credit = 1'b0;
        settle();
        check("outlim_extra_grants", grants, 1);
        check("outlim_tx_cnt", dut.tx_cnt, tx_lp);
        pulse(0, 4);

        // Simultaneous grant, credit return and response.
        lsu_v = 1'b1;
        next_cycle();
        remote_req_credit = 1'b1;
        resp_done         = 1'b1;
        settle();
        check("simul_grant", lsu_ready, 1);
        next_cycle();
        lsu_v             = 1'b0;
        remote_req_credit = 1'b0;
        resp_done         = 1'b0;
        settle();
        check("simul_tx_cnt", dut.tx_cnt, 1);
        check("simul_out_credits", out_credits, 3);
        pulse(1, 1);

        // Round robin with both valid, leaving 3 outstanding.
        ifetch_v = 1'b1;
        lsu_v    = 1'b1;
        settle();
        check("rr0_ifetch_ready", ifetch_ready, 1);
        next_cycle();
        remote_req_credit = 1'b1;
        settle();
        check("rr1_lsu_ready", lsu_ready, 1);
        next_cycle();
        settle();
        check("rr2_ifetch_ready", ifetch_ready, 1);
        next_cycle();
        ifetch_v = 1'b0;
        lsu_v    = 1'b0;
        settle();
        check("rr_out_credits", out_credits, 1);
        next_cycle();
        remote_req_credit = 1'b0;

        // Fence with 3 outstanding.
        fence = 1'b1;
        lsu_v = 1'b1;
        settle();
        check("fence_block_ready", lsu_ready, 0);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            resp_done = 1'b1;
            settle();
            check("fence_drain_ready", lsu_ready, 0);
            check("fence_drain_done", fence_done, 0);
            next_cycle();
        end
        resp_done = 1'b0;
        settle();
        check("fence_done_pulse", fence_done, 1);
        fence = 1'b0;
        settle();
        check("fence_resume_ready", lsu_ready, 1);
        next_cycle();
        lsu_v = 1'b0;
        settle();
        check("fence_done_single", fence_done, 0);
        pulse(1, 1);

        // Fence at full count, dropped early: drain still completes after one cycle.
        fence = 1'b1;
        settle();
        next_cycle();
        fence = 1'b0;
        lsu_v = 1'b1;
        settle();
        check("early_drain_ready", lsu_ready, 0);
        check("early_drain_done", fence_done, 0);
        next_cycle();
        lsu_v = 1'b0;
        settle();
        check("early_done_pulse", fence_done, 1);
        next_cycle();
        settle();
        check("early_done_single", fence_done, 0);

        // Reset during a drain.
        lsu_v = 1'b1;
        next_cycle();
        lsu_v = 1'b0;
        fence = 1'b1;
        next_cycle();
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        fence   = 1'b0;
        settle();
        check("rstdrain_out_credits", out_credits, max_lp);
        check("rstdrain_fence_done", fence_done, 0);
        check("rstdrain_tx_cnt", dut.tx_cnt, tx_lp);
        lsu_v = 1'b1;
        settle();
        check("rstdrain_normal_ready", lsu_ready, 1);
        next_cycle();
        lsu_v = 1'b0;
        settle();
        check("rstdrain_no_done", fence_done, 0);
        check("rstdrain_req_v", remote_req_v, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
